// File: rtl/coef_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coef_collector                                                             |
// | Packs one subgraph's attention coefficients into a single softmax word.    |
// | Optional: COEF_MAX_TRACK_EN adds sm_max_o, the running coefficient max.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module coef_collector #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_NODES      = 168,
  parameter int NUM_NODE_WIDTH = $clog2(MAX_NODES),
  localparam int SOFTMAX_WIDTH = MAX_NODES*DATA_WIDTH + NUM_NODE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     coef_ff_dout,
  input  logic                      coef_ff_empty,
  output logic                      coef_ff_rd_vld,
  input  logic [NUM_NODE_WIDTH-1:0] num_node_ff_dout,
  input  logic                      num_node_ff_empty,
  output logic                      num_node_ff_rd_vld,
  output logic [SOFTMAX_WIDTH-1:0]  sm_ff_din,
  input  logic                      sm_ff_full,
  output logic                      sm_ff_wr_vld,
  output logic                      busy_o
`ifdef COEF_MAX_TRACK_EN
  ,
  output logic [DATA_WIDTH-1:0]     sm_max_o
`endif
);

  localparam int BUF_WIDTH = MAX_NODES*DATA_WIDTH;

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_collect = 2'd1;
  localparam logic [1:0] c_push    = 2'd2;

  localparam logic [NUM_NODE_WIDTH-1:0] c_max_nodes = NUM_NODE_WIDTH'(MAX_NODES);

  logic [1:0]                r_state;
  logic [NUM_NODE_WIDTH-1:0] r_idx;
  logic [NUM_NODE_WIDTH-1:0] r_target;
  logic [BUF_WIDTH-1:0]      r_buf;

  logic                      w_pop_cnt;
  logic                      w_pop_coef;
  logic [NUM_NODE_WIDTH-1:0] w_target;
  logic [NUM_NODE_WIDTH-1:0] w_idx_nxt;

  // rst_n gates the pop so the output is low while reset is held even with data waiting
  assign w_pop_cnt  = rst_n && (r_state == c_idle) && !num_node_ff_empty;
  assign w_pop_coef = (r_state == c_collect) && !coef_ff_empty;
  assign w_target   = (num_node_ff_dout > c_max_nodes) ? c_max_nodes : num_node_ff_dout;
  assign w_idx_nxt  = r_idx + 1'b1;

  assign num_node_ff_rd_vld = w_pop_cnt;
  assign coef_ff_rd_vld     = w_pop_coef;
  assign sm_ff_wr_vld       = (r_state == c_push) && !sm_ff_full;
  assign sm_ff_din          = {r_buf, r_target};
  assign busy_o             = (r_state != c_idle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_idle;
      r_idx    <= '0;
      r_target <= '0;
      r_buf    <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_pop_cnt) begin
            r_target <= w_target;
            r_buf    <= '0;
            r_idx    <= '0;
            r_state  <= (w_target != '0) ? c_collect : c_push;
          end
        end
        c_collect: begin
          if (w_pop_coef) begin
            // Slot 0 sits at the MSBs so the first coefficient leads the word
            for (int k = 0; k < MAX_NODES; k++) begin
              if (r_idx == NUM_NODE_WIDTH'(k))
                r_buf[BUF_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH] <= coef_ff_dout;
            end
            r_idx <= w_idx_nxt;
            if (w_idx_nxt == r_target)
              r_state <= c_push;
          end
        end
        c_push: begin
          if (!sm_ff_full)
            r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

`ifdef COEF_MAX_TRACK_EN
  logic [DATA_WIDTH-1:0] r_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max <= '0;
    end else if (w_pop_cnt) begin
      r_max <= '0;
    end else if (w_pop_coef && (coef_ff_dout > r_max)) begin
      r_max <= coef_ff_dout;
    end
  end

  assign sm_max_o = r_max;
`else
  // Maximum tracking is not built in this configuration.
`endif

endmodule
`default_nettype wire
